// File: rtl/ballot_memory_unit.sv
// Per-candidate saturating vote tally with a saturating grand total.
// Outputs are registered and show the selected candidate's post-vote count.
module ballot_memory_unit #(
   parameter int NUM_CANDIDATES = 16,
   parameter int COUNT_W        = 4,
   parameter int TOTAL_W        = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         candidate_number,
   input  logic               vote_cast,
   output logic [3:0]         candidate_out,
   output logic [COUNT_W-1:0] vote_count,
   output logic [TOTAL_W-1:0] total_votes,
   output logic               saturated
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [TOTAL_W-1:0] TOT_MAX = '1;
   localparam logic [4:0]         NUM_C   = 5'(NUM_CANDIDATES);

   function automatic logic [COUNT_W-1:0] sat_inc_cnt(input logic [COUNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [TOTAL_W-1:0] sat_inc_total(input logic [TOTAL_W-1:0] v);
      return (v == TOT_MAX) ? v : v + 1'b1;
   endfunction

   // Sized to the full 4-bit index space so any candidate_number reads in range;
   // entries at or above NUM_CANDIDATES are never written and stay zero.
   logic [COUNT_W-1:0] mem_q [16];
   logic [3:0]         cand_q;
   logic [COUNT_W-1:0] count_q;
   logic [TOTAL_W-1:0] total_q;
   logic               sat_q;

   logic               cand_valid;
   logic [COUNT_W-1:0] cur_cnt;
   logic               accept;
   logic [COUNT_W-1:0] cnt_d;
   logic [TOTAL_W-1:0] total_d;

   always_comb begin
      cand_valid = ({1'b0, candidate_number} < NUM_C);
      cur_cnt    = mem_q[candidate_number];
      accept     = vote_cast && cand_valid && (cur_cnt != CNT_MAX);
      cnt_d      = accept ? sat_inc_cnt(cur_cnt) : cur_cnt;
      total_d    = accept ? sat_inc_total(total_q) : total_q;
   end

   // Register stage: tally update and bypassed readback on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem_q[i] <= '0;
         cand_q  <= '0;
         count_q <= '0;
         total_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         if (accept) mem_q[candidate_number] <= cnt_d;
         cand_q  <= candidate_number;
         count_q <= cand_valid ? cnt_d : '0;
         total_q <= total_d;
         sat_q   <= cand_valid && (cnt_d == CNT_MAX);
      end
   end

   assign candidate_out = cand_q;
   assign vote_count    = count_q;
   assign total_votes   = total_q;
   assign saturated     = sat_q;

endmodule

// File: tb/tb_ballot_memory_unit.sv
// Directed bench: a 16-candidate instance and a 4-candidate, 5-bit-total
// instance share stimulus; expected values are hand-computed constants.
module tb_ballot_memory_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] candidate_number;
   logic       vote_cast;

   logic [3:0] a_cand;
   logic [3:0] a_count;
   logic [7:0] a_total;
   logic       a_sat;

   logic [3:0] b_cand;
   logic [3:0] b_count;
   logic [4:0] b_total;
   logic       b_sat;

   int checks = 0;
   int errors = 0;

   ballot_memory_unit dut16 (
      .clk(clk), .rst_n(rst_n), .candidate_number(candidate_number), .vote_cast(vote_cast),
      .candidate_out(a_cand), .vote_count(a_count), .total_votes(a_total), .saturated(a_sat)
   );

   ballot_memory_unit #(.NUM_CANDIDATES(4), .COUNT_W(4), .TOTAL_W(5)) dut4 (
      .clk(clk), .rst_n(rst_n), .candidate_number(candidate_number), .vote_cast(vote_cast),
      .candidate_out(b_cand), .vote_count(b_count), .total_votes(b_total), .saturated(b_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] c, input logic v);
      candidate_number = c;
      vote_cast        = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int c, input int cnt, input int tot, input int s);
      check_eq({tag, ".cand"},  int'(a_cand),  c);
      check_eq({tag, ".count"}, int'(a_count), cnt);
      check_eq({tag, ".total"}, int'(a_total), tot);
      check_eq({tag, ".sat"},   int'(a_sat),   s);
   endtask

   task automatic check_b(input string tag, input int c, input int cnt, input int tot, input int s);
      check_eq({tag, ".cand"},  int'(b_cand),  c);
      check_eq({tag, ".count"}, int'(b_count), cnt);
      check_eq({tag, ".total"}, int'(b_total), tot);
      check_eq({tag, ".sat"},   int'(b_sat),   s);
   endtask

   initial begin
      rst_n            = 1'b0;
      candidate_number = 4'd0;
      vote_cast        = 1'b0;
      #12;
      check_a("reset16", 0, 0, 0, 0);
      check_b("reset4", 0, 0, 0, 0);
      #1 rst_n = 1'b1;

      // First vote for candidate 3
      step(4'd3, 1'b1);
      check_a("t1_vote", 3, 1, 1, 0);
      step(4'd3, 1'b0);
      check_a("t1_idle", 3, 1, 1, 0);

      // Two more votes while held high
      step(4'd3, 1'b1);
      check_a("t2_v1", 3, 2, 2, 0);
      step(4'd3, 1'b1);
      check_a("t2_v2", 3, 3, 3, 0);

      // Switch candidates, vote goes to the new index sampled at the edge
      step(4'd1, 1'b1);
      check_a("t3_c1", 1, 1, 4, 0);
      step(4'd2, 1'b1);
      check_a("t3_c2a", 2, 1, 5, 0);
      step(4'd2, 1'b1);
      check_a("t3_c2b", 2, 2, 6, 0);
      step(4'd3, 1'b0);
      check_a("t3_resel3", 3, 3, 6, 0);

      // Saturation on candidate 5 with vote_cast held 20 edges
      for (int i = 1; i <= 20; i++) begin
         step(4'd5, 1'b1);
         if (i == 14) check_a("t4_e14", 5, 14, 20, 0);
         if (i == 15) check_a("t4_e15", 5, 15, 21, 1);
      end
      check_a("t4_e20", 5, 15, 21, 1);
      step(4'd1, 1'b0);
      check_a("t4_other", 1, 1, 21, 0);

      // Asynchronous reset between edges
      step(4'd5, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_a("t5_async", 0, 0, 0, 0);
      check_b("t5_async4", 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      step(4'd1, 1'b0);
      check_a("t5_c1", 1, 0, 0, 0);
      step(4'd2, 1'b0);
      check_a("t5_c2", 2, 0, 0, 0);
      step(4'd3, 1'b0);
      check_a("t5_c3", 3, 0, 0, 0);

      // Invalid index on the 4-candidate instance
      for (int i = 0; i < 3; i++) step(4'd9, 1'b1);
      check_b("t6_invalid", 9, 0, 0, 0);
      check_a("t6_valid16", 9, 3, 3, 0);
      step(4'd9, 1'b0);
      check_b("t6_idle", 9, 0, 0, 0);

      // Fill candidates 0 and 1 of the small instance, then push the 5-bit total to its limit
      for (int i = 0; i < 16; i++) step(4'd0, 1'b1);
      check_b("t7_c0", 0, 15, 15, 1);
      for (int i = 0; i < 16; i++) step(4'd1, 1'b1);
      check_b("t7_c1", 1, 15, 30, 1);
      step(4'd2, 1'b1);
      check_b("t7_tot31", 2, 1, 31, 0);
      step(4'd2, 1'b1);
      check_b("t7_totsat", 2, 2, 31, 0);
      step(4'd0, 1'b0);
      check_b("t7_c0back", 0, 15, 31, 1);
      check_a("t7_tot16", 0, 15, 35, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ballot_memory_unit.md
Name: ballot_memory_unit

Overview:
Per-candidate vote tally memory for the electronic voting machine. It holds one saturating vote counter per candidate and increments the selected candidate's counter on every clock edge where vote_cast is high. It presents the selected candidate number and that candidate's up-to-date count on registered outputs. It sits between the ballot input/selection logic and the result display.

Parameters:
NUM_CANDIDATES, 16, number of candidate counters (1..16); candidate indices 0..NUM_CANDIDATES-1 are valid.
COUNT_W, 4, width of each per-candidate vote counter and of vote_count.
TOTAL_W, 8, width of the total_votes accumulator.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
candidate_number  input  4  candidate selected for voting and readback.
vote_cast  input  1  level-sensitive vote strobe; one vote counted per rising clk edge while high.
candidate_out  output  4  registered copy of candidate_number.
vote_count  output  COUNT_W  registered count of the selected candidate, including any vote counted on the same edge.
total_votes  output  TOTAL_W  registered total of all votes accepted.
saturated  output  1  registered; high when the selected candidate's counter is at its maximum, 2^COUNT_W-1.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - all per-candidate counters clear to 0;
  - candidate_out = 0, vote_count = 0, total_votes = 0, saturated = 0.
  - State stays held while rst_n is low. First update occurs on the first rising edge after rst_n goes high.
- Valid index: candidate_number < NUM_CANDIDATES.
- On each rising clk edge (rst_n high), with c = candidate_number:
  - A vote is accepted when vote_cast = 1, c is valid, and mem[c] < 2^COUNT_W-1.
  - If accepted: mem[c] <= mem[c]+1 and total_votes <= total_votes+1.
  - total_votes saturates at 2^TOTAL_W-1. A vote that increments mem[c] when total_votes is already at maximum still counts in mem[c]; total_votes stays at maximum.
  - candidate_out <= c, every cycle, regardless of vote_cast or validity.
  - vote_count <= the new value of mem[c], i.e. post-increment. Read-after-write in the same cycle is bypassed, so the output is never one vote stale.
  - If c is invalid: vote_count <= 0 and no counter changes.
  - saturated <= (new mem[c] == 2^COUNT_W-1) for valid c; 0 for invalid c.
- vote_cast held high for N edges gives N votes; there is no edge detection or debounce, which is upstream's job.
- Holding vote_cast high at a saturated counter: no change to mem[c] or total_votes, and saturated stays 1. There is no wrap-around.
- Changing candidate_number without vote_cast: outputs update after one edge to show the new candidate's stored count. Other candidates' counts are untouched.
- Changing candidate_number and asserting vote_cast in the same cycle: the vote goes to the new candidate number sampled at that edge.
- Reset asserted mid-operation clears all tallies. There is no partial retention.
- Latency: one clock from input sample to output.
- No other state; no FSM.

Test Plan:
1. Reset, then candidate_number=3, vote_cast=1 for 1 edge, then 0 -> candidate_out=3, vote_count=1, total_votes=1, saturated=0.
2. Continue on candidate 3 with vote_cast high for 2 edges -> candidate_out=3, vote_count=3, total_votes=3.
3. Switch to candidate 1 with 1 vote, then candidate 2 with 2 votes -> after each: (1,1) then (2,2); total_votes=6. Reselect 3 with vote_cast=0 -> vote_count=3 after one edge.
4. Saturation: candidate 5 with vote_cast held for 20 edges -> vote_count=15, saturated=1; total_votes increases by exactly 15.
5. Asynchronous reset asserted mid-stream, between clock edges -> all outputs 0 immediately. Reselect candidates 1, 2 and 3 -> vote_count=0 for each.
6. With NUM_CANDIDATES=4: candidate_number=9 and vote_cast=1 for 3 edges -> candidate_out=9, vote_count=0, saturated=0, total_votes unchanged.
